// File: rtl/reg_hazard_scoreboard.sv
// reg_hazard_scoreboard: stalls ID on load-use and on hazards against the single
// outstanding multi-cycle hash result; launches the hash unit and watches for timeout.
`default_nettype none

module reg_hazard_scoreboard #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_id_Valid,
    input  logic [4:0]  if_id_RegisterRs,
    input  logic [4:0]  if_id_RegisterRt,
    input  logic        if_id_UseRt,
    input  logic        if_id_RegWrite,
    input  logic [4:0]  if_id_RegisterRd,
    input  logic        if_id_MultiCycle,
    input  logic        id_ex_MemRead,
    input  logic [4:0]  id_ex_RegisterRt,
    input  logic        mc_Done,
    output logic        Stall,
    output logic        id_ex_Bubble,
    output logic        mc_Start,
    output logic [4:0]  mc_RegisterRd,
    output logic        mc_Busy,
    output logic        mc_Error,
    output logic [31:0] Pending
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_TIMEOUT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      pend_q, pend_d;

    logic        in_busy, in_tmo;
    logic [31:0] rd_mask, eff;
    logic        lu, raw, waw, st, hazard, issue;

    assign in_busy = (state_q == S_BUSY);
    assign in_tmo  = (state_q == S_TIMEOUT);
    assign rd_mask = 32'd1 << rd_q;

    // A result written back this cycle reaches its consumer through forwarding.
    assign eff = (mc_Done && in_busy) ? (pend_q & ~rd_mask) : pend_q;

    assign lu  = id_ex_MemRead && (id_ex_RegisterRt != 5'd0) &&
                 ((id_ex_RegisterRt == if_id_RegisterRs) ||
                  (if_id_UseRt && (id_ex_RegisterRt == if_id_RegisterRt)));
    assign raw = eff[if_id_RegisterRs] || (if_id_UseRt && eff[if_id_RegisterRt]);
    assign waw = if_id_RegWrite && eff[if_id_RegisterRd];
    assign st  = if_id_MultiCycle && ((in_busy && !mc_Done) || in_tmo);

    assign hazard = if_id_Valid && (lu || raw || waw || st);
    assign issue  = if_id_Valid && if_id_MultiCycle && !hazard;

    assign Stall         = hazard && !rst;
    assign id_ex_Bubble  = hazard && !rst;
    assign mc_Start      = issue && !rst;
    assign mc_RegisterRd = rd_q;
    assign mc_Busy       = in_busy;
    assign mc_Error      = in_tmo;
    assign Pending       = pend_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        pend_d  = pend_q;
        case (state_q)
            S_BUSY: begin
                cnt_d = cnt_q + CNT_ONE;
                if (mc_Done) begin
                    pend_d  = pend_q & ~rd_mask;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_TIMEOUT;
                end
            end
            S_TIMEOUT: begin
                pend_d  = pend_q & ~rd_mask;
                state_d = S_IDLE;
            end
            default: ;
        endcase
        // Issue overrides the completion path so back-to-back hashes keep BUSY.
        if (issue) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            rd_d    = if_id_RegisterRd;
            if (if_id_RegisterRd != 5'd0)
                pend_d = pend_d | (32'd1 << if_id_RegisterRd);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            pend_q  <= pend_d;
        end
    end

endmodule

`default_nettype wire
